// File: rtl/cfg_pkg.sv
// Shared constants, FSM states and header helpers for the config-latch loader.
// Pure declarations: no latency.
// No flow control of its own.
package cfg_pkg;

    localparam int DATA_W        = 32;
    localparam int N_WORDS       = 33;
    localparam int IDX_W         = 6;
    localparam int HDR_START_LSB = 0;
    localparam int HDR_COUNT_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] start;
        logic [IDX_W-1:0] count;
    } hdr_t;

    function automatic hdr_t hdr_unpack(input logic [DATA_W-1:0] word);
        hdr_t h;
        h.start = word[HDR_START_LSB +: IDX_W];
        h.count = word[HDR_COUNT_LSB +: IDX_W];
        return h;
    endfunction

    // One extra bit on the sum so start+count can never wrap past the bank end.
    function automatic logic hdr_legal(input hdr_t h);
        logic [IDX_W:0] last;
        last = {1'b0, h.start} + {1'b0, h.count};
        return (h.count != '0) && (last <= (IDX_W+1)'(N_WORDS));
    endfunction

endpackage

// File: rtl/cfg_onehot_dec.sv
// Slot index to one-hot latch-enable decoder; indices past the bank give all zeros.
// Latency: combinational.
// No flow control.
module cfg_onehot_dec
    import cfg_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [N_WORDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/config_load_ctrl.sv
// Loads a header + data burst into the config latch bank with set-up/strobe/hold per word.
// Latency: strobe two cycles after a data word is accepted, 4 cycles per word minimum.
// Backpressure: io_in_ready is high only in IDLE and WAIT; abort drops the burst.
module config_load_ctrl
    import cfg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [DATA_W-1:0]  io_in_bits,
    input  logic               io_abort,
    output logic [DATA_W-1:0]  io_d_in,
    output logic [N_WORDS-1:0] io_configs_en,
    output logic               io_busy,
    output logic               io_done,
    output logic               io_err
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   rem;
    logic [N_WORDS-1:0] idx_onehot;
    hdr_t               hdr;
    logic               hdr_ok;
    logic               in_acc;

    assign hdr    = hdr_unpack(io_in_bits);
    assign hdr_ok = hdr_legal(hdr);
    // Abort wins over any word presented in the same cycle.
    assign in_acc = io_in_valid && io_in_ready && !io_abort;

    cfg_onehot_dec u_dec (
        .idx    (idx),
        .onehot (idx_onehot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (io_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_acc && hdr_ok) state_nxt = WAIT;
                WAIT:    if (in_acc) state_nxt = SETUP;
                SETUP:   state_nxt = STROBE;
                STROBE:  state_nxt = HOLD;
                HOLD:    state_nxt = (rem == IDX_W'(1)) ? DONE : WAIT;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        io_in_ready = (state == IDLE) || (state == WAIT);
        io_busy     = (state != IDLE);
        io_done     = (state == DONE);
    end

    // Enables are registered so the strobe is a clean single-cycle pulse with data already settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_d_in       <= '0;
            io_configs_en <= '0;
            io_err        <= 1'b0;
            idx           <= '0;
            rem           <= '0;
        end else begin
            io_configs_en <= (state == SETUP && !io_abort) ? idx_onehot : '0;

            if (state == IDLE && in_acc) begin
                if (hdr_ok) begin
                    io_err <= 1'b0;
                    idx    <= hdr.start;
                    rem    <= hdr.count;
                end else begin
                    io_err <= 1'b1;
                end
            end

            if (state == WAIT && in_acc) begin
                io_d_in <= io_in_bits;
            end

            if (state == HOLD && !io_abort) begin
                idx <= idx + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_load_ctrl.sv
// Randomized bench for config_load_ctrl against a countdown-based write-schedule model.
module tb_config_load_ctrl;

    localparam int DW = 32;
    localparam int NW = 33;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_bits  = '0;
    logic          abort_i  = 1'b0;
    logic [DW-1:0] d_in;
    logic [NW-1:0] cfg_en;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    config_load_ctrl dut (
        .clk           (clk),
        .reset         (rst_n),
        .io_in_valid   (in_valid),
        .io_in_ready   (in_ready),
        .io_in_bits    (in_bits),
        .io_abort      (abort_i),
        .io_d_in       (d_in),
        .io_configs_en (cfg_en),
        .io_busy       (busy),
        .io_done       (done),
        .io_err        (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Model: a burst is "busy" with m_cyc counting cycles since a data word was taken (0 = waiting).
    bit            m_busy, m_done, m_err;
    int            m_cyc, m_slot, m_left;
    int            h_st, h_cnt;
    logic [DW-1:0] m_d;
    logic [DW-1:0] exp_bank [NW];
    logic [DW-1:0] obs_bank [NW];
    int            strobes  [NW];
    int            strobe_cyc [NW];
    int            done_cnt = 0;

    function automatic bit exp_ready();
        return !m_busy || (m_cyc == 0 && !m_done);
    endfunction

    function automatic logic [NW-1:0] exp_en();
        logic [NW-1:0] e;
        e = '0;
        if (m_cyc == 2 && m_slot < NW) e[m_slot] = 1'b1;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0;
            m_cyc = 0; m_slot = 0; m_left = 0; m_d = '0;
        end else begin
            if (m_cyc == 2) exp_bank[m_slot] = m_d;
            if (!m_busy) begin
                if (in_valid && !abort_i) begin
                    h_st  = int'(in_bits[5:0]);
                    h_cnt = int'(in_bits[21:16]);
                    if (h_cnt > 0 && h_st + h_cnt <= NW) begin
                        m_busy = 1; m_err = 0; m_slot = h_st; m_left = h_cnt; m_cyc = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (abort_i) begin
                m_busy = 0; m_done = 0; m_cyc = 0;
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (m_cyc == 0) begin
                if (in_valid) begin m_d = in_bits; m_cyc = 1; end
            end else if (m_cyc < 3) begin
                m_cyc++;
            end else begin
                m_cyc = 0; m_slot++; m_left--;
                if (m_left == 0) m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ready",   64'(in_ready), 64'(exp_ready()));
        check("busy",    64'(busy),     64'(m_busy));
        check("done",    64'(done),     64'(m_done));
        check("err",     64'(err),      64'(m_err));
        check("en",      64'(cfg_en),   64'(exp_en()));
        check("d_in",    64'(d_in),     64'(m_d));
        check("onehot0", 64'($onehot0(cfg_en)), 64'd1);
        for (int i = 0; i < NW; i++) begin
            if (cfg_en[i]) begin
                obs_bank[i]   = d_in;
                strobes[i]    = strobes[i] + 1;
                strobe_cyc[i] = cycle;
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds valid until the model says the word went in; leaves valid high afterwards.
    task automatic push(input logic [DW-1:0] w);
        int guard;
        bit acc;
        guard = 0;
        in_valid = 1'b1;
        in_bits  = w;
        do begin
            acc = exp_ready() && !abort_i;
            tick();
            guard++;
        end while (!acc && guard < 50);
        check("push_accept_timeout", 64'(acc), 64'd1);
    endtask

    function automatic logic [DW-1:0] hdr(input int st, input int cnt);
        return (DW'(cnt) << 16) | DW'(st);
    endfunction

    int            tot0, dn0, s5, s6;
    logic [DW-1:0] words [NW];
    logic [DW-1:0] hbits;
    bit            acc_r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NW; i++) begin
            exp_bank[i] = '0; obs_bank[i] = '0; strobes[i] = 0; strobe_cyc[i] = 0;
        end
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        tick(2);

        // Reset state
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_en",    64'(cfg_en),   64'd0);
        check("rst_d_in",  64'(d_in),     64'd0);
        check("rst_err",   64'(err),      64'd0);

        // Single word to slot 0
        push(hdr(0, 1));
        push(32'hDEADBEEF);
        in_valid = 1'b0;
        check("t1_setup_d",  64'(d_in),   64'hDEADBEEF);
        check("t1_setup_en", 64'(cfg_en), 64'd0);
        tick();
        check("t1_strobe_en", 64'(cfg_en), 64'd1);
        check("t1_strobe_d",  64'(d_in),   64'hDEADBEEF);
        tick();
        check("t1_hold_en", 64'(cfg_en), 64'd0);
        check("t1_hold_d",  64'(d_in),   64'hDEADBEEF);
        tick();
        check("t1_done", 64'(done), 64'd1);
        tick();
        check("t1_done_gone", 64'(done), 64'd0);
        check("t1_idle",      64'(busy), 64'd0);

        // Back-to-back words to the top three slots
        dn0 = done_cnt;
        push(hdr(30, 3));
        push(32'hAAAA0001);
        push(32'hBBBB0002);
        push(32'hCCCC0003);
        in_valid = 1'b0;
        tick(6);
        check("t2_gap_30_31", 64'(strobe_cyc[31] - strobe_cyc[30]), 64'd4);
        check("t2_gap_31_32", 64'(strobe_cyc[32] - strobe_cyc[31]), 64'd4);
        check("t2_bank30", 64'(obs_bank[30]), 64'hAAAA0001);
        check("t2_bank31", 64'(obs_bank[31]), 64'hBBBB0002);
        check("t2_bank32", 64'(obs_bank[32]), 64'hCCCC0003);
        check("t2_done",   64'(done_cnt - dn0), 64'd1);

        // Illegal headers
        tot0 = 0;
        for (int i = 0; i < NW; i++) tot0 += strobes[i];
        push(hdr(32, 2));
        in_valid = 1'b0;
        check("t3_err_range", 64'(err),      64'd1);
        check("t3_ready",     64'(in_ready), 64'd1);
        check("t3_busy",      64'(busy),     64'd0);
        push(hdr(0, 0));
        in_valid = 1'b0;
        check("t3_err_zero", 64'(err), 64'd1);
        tick(3);
        s5 = 0;
        for (int i = 0; i < NW; i++) s5 += strobes[i];
        check("t3_no_strobe", 64'(s5), 64'(tot0));
        push(hdr(3, 1));
        check("t3_err_clear", 64'(err), 64'd0);
        push(32'h0000_3333);
        in_valid = 1'b0;
        tick(6);

        // Abort in the SETUP of the second word
        dn0 = done_cnt; s5 = strobes[5]; s6 = strobes[6];
        push(hdr(5, 4));
        push(32'h5555_0005);
        in_valid = 1'b0;
        tick(3);
        push(32'h6666_0006);
        in_valid = 1'b0;
        abort_i  = 1'b1;
        tick();
        abort_i  = 1'b0;
        check("t4_idle", 64'(busy),   64'd0);
        check("t4_en",   64'(cfg_en), 64'd0);
        tick(6);
        check("t4_slot5", 64'(strobes[5] - s5), 64'd1);
        check("t4_slot6", 64'(strobes[6] - s6), 64'd0);
        check("t4_done",  64'(done_cnt - dn0),  64'd0);

        // Asynchronous reset in the middle of a strobe
        push(hdr(10, 1));
        push(32'h1010_1010);
        in_valid = 1'b0;
        tick();
        check("t5_strobe", 64'(cfg_en), 64'(33'd1 << 10));
        #2 rst_n = 1'b0;
        #1;
        check("t5_en",    64'(cfg_en),   64'd0);
        check("t5_busy",  64'(busy),     64'd0);
        check("t5_ready", 64'(in_ready), 64'd1);
        #3 rst_n = 1'b1;
        tick(2);

        // Full bank with random valid gaps
        dn0 = done_cnt;
        for (int i = 0; i < NW; i++) begin
            words[i] = $urandom;
            strobes[i] = 0;
        end
        push(hdr(0, NW));
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b0;
            tick($urandom_range(0, 3));
            push(words[i]);
        end
        in_valid = 1'b0;
        tick(6);
        check("t6_done", 64'(done_cnt - dn0), 64'd1);
        for (int i = 0; i < NW; i++) begin
            check("t6_once", 64'(strobes[i]),  64'd1);
            check("t6_data", 64'(obs_bank[i]), 64'(words[i]));
        end

        // Random headers, words, gaps and aborts
        for (int c = 0; c < 2000; c++) begin
            abort_i = ($urandom_range(0, 39) == 0);
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                if (!m_busy) begin
                    hbits = $urandom;
                    hbits[5:0]   = 6'($urandom_range(0, 40));
                    hbits[21:16] = 6'($urandom_range(0, 6));
                    in_bits = hbits;
                end else begin
                    in_bits = $urandom;
                end
            end
            acc_r = in_valid && exp_ready() && !abort_i;
            tick();
            if (acc_r) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        abort_i  = 1'b0;
        tick(10);
        for (int i = 0; i < NW; i++)
            check("bank_final", 64'(obs_bank[i]), 64'(exp_bank[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
